// File: rtl/tdm_demux_8.sv
// rtl/tdm_demux_8.sv - 1-to-8 TDM demultiplexer with slot-0 frame-sync lock
module tdm_demux_8 #(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       en,
    input  logic       sync,
    output logic [7:0] o,
    output logic [2:0] slot,
    output logic       locked,
    output logic       frame_valid,
    output logic       sync_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_slot,   w_slot_nxt;
    logic [6:0] r_shadow, w_shadow_nxt;
    logic [7:0] r_o,      w_o_nxt;
    logic       r_fv,     w_fv_nxt;
    logic       r_err,    w_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_slot   <= 3'd0;
            r_shadow <= 7'd0;
            r_o      <= 8'h00;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_shadow <= w_shadow_nxt;
            r_o      <= w_o_nxt;
            r_fv     <= w_fv_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_shadow_nxt = r_shadow;
        w_o_nxt      = r_o;
        w_fv_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (sync) begin
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 3'd1;
                        w_state_nxt     = ST_RUN;
                    end
                end
                default: begin
                    if (r_slot == 3'd0) begin
                        if (sync || !SYNC_CHECK) begin
                            w_shadow_nxt[0] = din;
                            w_slot_nxt      = 3'd1;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (sync) begin
                        // Premature marker outranks completion: restart the frame at slot 0.
                        w_err_nxt       = 1'b1;
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 3'd1;
                    end else if (r_slot == 3'd7) begin
                        w_o_nxt    = {din, r_shadow};
                        w_fv_nxt   = 1'b1;
                        w_slot_nxt = 3'd0;
                    end else begin
                        for (int k = 0; k < 7; k++) begin
                            if (r_slot == 3'(k)) w_shadow_nxt[k] = din;
                        end
                        w_slot_nxt = r_slot + 3'd1;
                    end
                end
            endcase
        end
    end

    assign o           = r_o;
    assign slot        = r_slot;
    assign locked      = (r_state == ST_RUN);
    assign frame_valid = r_fv;
    assign sync_err    = r_err;

endmodule

// File: tb/tb_tdm_demux_8.sv
// tb/tb_tdm_demux_8.sv - self-checking bench for tdm_demux_8 (SYNC_CHECK=1 and 0)
module tb_tdm_demux_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] o_a, o_b;
    logic [2:0] slot_a, slot_b;
    logic       locked_a, locked_b, fv_a, fv_b, err_a, err_b;

    int total = 0;
    int bad = 0;

    // Instance A checks sync every frame; instance B only needs it to lock.
    tdm_demux_8 #(.SYNC_CHECK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .o(o_a), .slot(slot_a), .locked(locked_a),
        .frame_valid(fv_a), .sync_err(err_a)
    );

    tdm_demux_8 #(.SYNC_CHECK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .o(o_b), .slot(slot_b), .locked(locked_b),
        .frame_valid(fv_b), .sync_err(err_b)
    );

    always #5 clk = ~clk;

    // Model: a frame is a list of received bits; its length is the slot index.
    bit         m_lock [2];
    int         m_cnt  [2];
    logic [7:0] m_bits [2];
    logic [7:0] m_o    [2];
    bit         m_fv   [2];
    bit         m_err  [2];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input bit sc);
        m_fv[m]  = 1'b0;
        m_err[m] = 1'b0;
        if (en) begin
            if (!m_lock[m]) begin
                if (sync) begin
                    m_lock[m] = 1'b1;
                    m_bits[m] = {7'd0, din};
                    m_cnt[m]  = 1;
                end
            end else if (sync && m_cnt[m] != 0) begin
                m_err[m]  = 1'b1;
                m_bits[m] = {7'd0, din};
                m_cnt[m]  = 1;
            end else if (m_cnt[m] == 0) begin
                if (sync || !sc) begin
                    m_bits[m] = {7'd0, din};
                    m_cnt[m]  = 1;
                end else begin
                    m_err[m]  = 1'b1;
                    m_lock[m] = 1'b0;
                end
            end else begin
                m_bits[m] = m_bits[m] | (8'(din) << m_cnt[m]);
                m_cnt[m]  = m_cnt[m] + 1;
                if (m_cnt[m] == 8) begin
                    m_o[m]   = m_bits[m];
                    m_fv[m]  = 1'b1;
                    m_cnt[m] = 0;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_lock[m] = 1'b0; m_cnt[m] = 0; m_bits[m] = 8'h00;
                m_o[m] = 8'h00; m_fv[m] = 1'b0; m_err[m] = 1'b0;
            end
        end else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a.o", o_a, m_o[0]);
            chk("a.slot", 8'(slot_a), 8'(m_cnt[0]));
            chk("a.locked", 8'(locked_a), 8'(m_lock[0]));
            chk("a.frame_valid", 8'(fv_a), 8'(m_fv[0]));
            chk("a.sync_err", 8'(err_a), 8'(m_err[0]));
            chk("b.o", o_b, m_o[1]);
            chk("b.slot", 8'(slot_b), 8'(m_cnt[1]));
            chk("b.locked", 8'(locked_b), 8'(m_lock[1]));
            chk("b.frame_valid", 8'(fv_b), 8'(m_fv[1]));
            chk("b.sync_err", 8'(err_b), 8'(m_err[1]));
        end
    end

    task automatic cyc(input logic e, input logic s, input logic d);
        en = e; sync = s; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, k == 0, v[k]);
            if (gaps && k != 7) begin
                cyc(1'b0, 1'b1, 1'b1);
                cyc(1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b1);
        chk("idle_no_sync_slot", 8'(slot_a), 8'd0);
        chk("idle_no_sync_lock", 8'(locked_a), 8'd0);

        // Single frame, slots 0..7 carry 1,0,1,1,0,0,1,0.
        send_frame(8'h4D, 1'b0);
        chk("single_o", o_a, 8'h4D);
        chk("single_fv", 8'(fv_a), 8'd1);
        chk("single_slot", 8'(slot_a), 8'd0);
        chk("single_locked", 8'(locked_a), 8'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("single_fv_drop", 8'(fv_a), 8'd0);

        // Back-to-back frames.
        send_frame(8'hA5, 1'b0);
        chk("b2b_o_a5", o_a, 8'hA5);
        send_frame(8'h3C, 1'b0);
        chk("b2b_o_3c", o_a, 8'h3C);
        chk("b2b_fv", 8'(fv_a), 8'd1);

        // Premature sync at slot 4, then a complete restarted frame.
        v = 8'h77;
        for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, v[k]);
        v = 8'h96;
        cyc(1'b1, 1'b1, v[0]);
        chk("premature_err", 8'(err_a), 8'd1);
        chk("premature_slot", 8'(slot_a), 8'd1);
        chk("premature_o", o_a, 8'h3C);
        for (int k = 1; k < 8; k++) cyc(1'b1, 1'b0, v[k]);
        chk("restart_o", o_a, 8'h96);

        // Missing sync at slot 0.
        v = 8'hC3;
        cyc(1'b1, 1'b0, v[0]);
        chk("nosync_a_err", 8'(err_a), 8'd1);
        chk("nosync_a_locked", 8'(locked_a), 8'd0);
        chk("nosync_b_err", 8'(err_b), 8'd0);
        for (int k = 1; k < 8; k++) cyc(1'b1, 1'b0, v[k]);
        chk("nosync_a_o_held", o_a, 8'h96);
        chk("nosync_a_slot", 8'(slot_a), 8'd0);
        chk("nosync_b_o", o_b, 8'hC3);
        chk("nosync_b_fv", 8'(fv_b), 8'd1);

        // Gapped strobes give the same frame as the gap-free case.
        send_frame(8'h4D, 1'b1);
        chk("gapped_a_o", o_a, 8'h4D);
        chk("gapped_b_o", o_b, 8'h4D);

        // Reset after slot 5, asserted between edges.
        v = 8'hFF;
        for (int k = 0; k < 6; k++) cyc(1'b1, k == 0, v[k]);
        en = 1'b0; sync = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_o", o_a, 8'h00);
        chk("rst_async_slot", 8'(slot_a), 8'd0);
        chk("rst_async_locked", 8'(locked_a), 8'd0);
        chk("rst_async_fv", 8'(fv_a), 8'd0);
        chk("rst_async_b_o", o_b, 8'h00);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("post_rst_o", o_a, 8'h00);
        chk("post_rst_locked", 8'(locked_a), 8'd0);
        send_frame(8'hE1, 1'b0);
        chk("fresh_o", o_a, 8'hE1);
        chk("fresh_fv", 8'(fv_a), 8'd1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_8.md
Name: tdm_demux_8

Overview:
- 1-to-8 time-division demultiplexer that receives one serial bit per slot strobe and distributes it to eight parallel lanes.
- It is the receive end of the 8:1 select path: the transmit side steps its 3-bit select from 0 to 7 and sends one bit per slot.
- This block tracks the slot index, uses a frame-sync marker on slot 0 to lock, and presents a complete 8-bit frame on registered outputs.

Parameters:
- SYNC_CHECK, default 1: when 1, a strobe at slot 0 must carry sync or the block drops lock; when 0, sync is only required for initial lock.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit for the current slot; sampled only when en=1.
- en  input  1  slot strobe; one slot consumed per clk cycle with en=1.
- sync  input  1  frame marker; qualified by en; asserted together with the slot-0 bit.
- o  output  8  last complete frame; o[k] = bit received in slot k.
- slot  output  3  index of the next slot to be written.
- locked  output  1  1 while in RUN state.
- frame_valid  output  1  one-cycle pulse, asserted the cycle o updates.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, rst=1):
  - o=8'h00, slot=0, locked=0, frame_valid=0, sync_err=0.
  - Shadow register = 0; state=IDLE.
  - Reset mid-frame discards partial data immediately.
- State IDLE:
  - en=0: no change.
  - en=1, sync=0: bit ignored, slot stays 0, no error pulse.
  - en=1, sync=1: shadow[0]<=din, slot<=1, state<=RUN.
- State RUN, en=1, slot=s in 1..6:
  - shadow[s]<=din, slot<=s+1.
  - If sync=1 here (premature marker): sync_err pulse. Treat as a new frame: shadow[0]<=din, slot<=1, state stays RUN. Partial frame discarded, o unchanged.
- State RUN, en=1, slot=7:
  - o<={din, shadow[6:0]}, frame_valid=1 in that same register update (visible the cycle after the strobe edge).
  - slot<=0 (wrap).
  - sync=1 at slot 7 is a violation and is handled as above; the premature-marker rule has priority over frame completion.
- State RUN, en=1, slot=0:
  - sync=1: shadow[0]<=din, slot<=1.
  - sync=0 and SYNC_CHECK=1: sync_err pulse, bit dropped, slot stays 0, state<=IDLE, locked<=0.
  - sync=0 and SYNC_CHECK=0: accepted as slot 0, shadow[0]<=din, slot<=1.
- en=0 in any state: hold all state; frame_valid and sync_err deassert.
- Pulse behaviour: frame_valid and sync_err are registered and last exactly one cycle. They never assert together.
- Latency: the bit strobed in slot 7 and bits 0..6 appear on o one clk after the slot-7 strobe edge.
- Output holding: o holds its value between frames; it changes only on frame completion or reset.
- Back-to-back operation: frames may run with en held high continuously, giving one frame_valid every 8 cycles.

Test Plan:
- Reset check: assert rst asynchronously between edges -> o=00, slot=0, locked=0, frame_valid=0 at once, without waiting for a clock edge.
- Single frame: en=1 for 8 cycles, sync=1 on the first, din = 1,0,1,1,0,0,1,0 (slots 0..7) -> one cycle after the 8th strobe o=8'h4D and frame_valid=1 for one cycle; slot=0; locked=1.
- Back-to-back frames: 16 continuous strobes, sync on cycles 0 and 8, data frame A=8'hA5 then B=8'h3C -> frame_valid pulses 8 cycles apart; o=A5 then 3C.
- Premature sync: sync reasserted at slot 4 mid-frame -> sync_err pulse, slot=1, o unchanged. The following 7 strobes complete a new frame with the correct value.
- Missing sync, SYNC_CHECK=1: slot 0 strobe with sync=0 after a good frame -> sync_err pulse, locked=0. Subsequent strobes are ignored until sync returns; with SYNC_CHECK=0 the same stimulus instead yields a valid second frame.
- Gapped strobes and reset mid-frame: insert en=0 gaps between slots of a frame -> o identical to the gap-free case. Separately, assert rst after slot 5 -> o stays 00, and no frame_valid occurs until a fresh sync-led frame.
